tbec_rsc_write_port: RTL and testbench
======================================

Name: tbec_rsc_write_port

Overview:
- Upstream stage of the TBEC-RSC memory path.
- Accepts 16-bit user words over a valid/ready stream and computes the 16 redundancy bits of the TBEC-RSC code.
- Writes each 32-bit codeword to memory as a burst with an auto-incrementing address.
- Its output is exactly the codeword format the TBEC-RSC decoder consumes on read-back.

Parameters:
- ADDR_W, 10, memory word-address width.
- LEN_W, 10, burst-length counter width.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; starts a burst (ignored unless IDLE)
- base_addr  in  ADDR_W  first write address, sampled on start
- burst_len  in  LEN_W  number of words, sampled on start; 0 means immediate DONE
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse when the last write is accepted
- in_valid  in  1  user word valid
- in_data  in  16  user word, bit 0 = MSB (index [0:15])
- in_ready  out  1  word accepted when in_valid & in_ready
- mem_wr_valid  out  1  write request valid
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  32  codeword, index [0:31]
- mem_wr_ready  in  1  memory accepts when mem_wr_valid & mem_wr_ready

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; address and counters 0; holding register empty.
- Encoding (combinational on in_data, registered on accept). Let d=in_data[0:15] and s[r][k]=d[4r+k], r,k in 0..3.
  - Data placement: cw[r+4k]=d[4r+k]. This is a transpose, so the decoder's output equals d.
  - Row bits, r=0..3: red[8+2r]=s[r][0]^s[r][2]; red[9+2r]=s[r][1]^s[r][3].
  - Pair bits: red[4]=s0[0]^s0[1]^s1[0]^s1[1]; red[6]=s2[0]^s2[1]^s3[0]^s3[1]; red[7]=s0[2]^s0[3]^s1[2]^s1[3]; red[5]=s2[2]^s2[3]^s3[2]^s3[3].
  - Diagonal bits: red[0]=s0[0]^s1[1]^s2[0]^s3[1]; red[2]=s0[1]^s1[0]^s2[1]^s3[0]; red[3]=s0[2]^s1[3]^s2[2]^s3[3]; red[1]=s0[3]^s1[2]^s2[3]^s3[2].
  - Placement: cw[16+i]=red[i]. An error-free codeword produces all-zero decoder syndromes.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> load addr=base_addr, remaining=burst_len. Go to RUN if burst_len!=0, else DONE.
  - RUN: in_ready = !hold_full | mem_wr_ready. Each input accept loads the holding register (mem_wr_valid=1, addr=current) and decrements remaining. The accept that makes remaining 0 -> DRAIN.
  - DRAIN: in_ready=0; wait for the final write handshake -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Handshake: latency is 1 cycle from input accept to mem_wr_valid. Back-to-back operation is supported at full rate when mem_wr_ready is held high. mem_wr_valid/addr/data stay stable while valid & !ready.
- Simultaneous events:
  - A write handshake and an input accept in the same cycle refill the holding register; no bubble.
  - Address increments by 1 per accepted input and wraps modulo 2^ADDR_W.
- start while not IDLE is ignored.
- Reset mid-burst drops the pending write; no done pulse.

Optional Feature:
- TBEC_ERR_INJECT_EN adds input port inj_mask (32) and inj_en (1).
  - With the macro: when inj_en=1 at input accept, the stored codeword = cw ^ inj_mask. This is used to exercise decoder correction.
  - Without the macro: the ports are absent and the codeword is never altered.

Decomposition:
- Package tbec_rsc_pkg: DATA_W=16, CW_W=32, state enum typedef, codeword struct/typedef, and a function tbec_rsc_encode(16)->32 shared with the scoreboard.
- One sub-module, tbec_rsc_encoder: combinational 16->32 mapping.
- FSM and holding register stay in the top.

Test Plan:
- Single word: base=0x010, len=1, in_data=16'h8000 -> one write, addr 0x010, data 32'h8000_8880; done pulses one cycle after the write handshake.
- Encoding corners: in_data=16'h0000 -> 32'h0000_0000; in_data=16'hFFFF -> 32'hFFFF_0000.
- Round trip: 256 random words encoded, then passed through the decoder with 0/1-bit flips -> decoder output equals the original word.
- Backpressure: len=4, mem_wr_ready toggles 1010... -> addresses base..base+3 in order; data stable while stalled; in_ready low while the holding register is full and not draining.
- Wrap and zero length: base=0x3FE, len=3 -> addresses 0x3FE, 0x3FF, 0x000. Separately, len=0 -> done one cycle after start with no writes.
- Reset mid-burst: rst asserted after 2 of 5 writes -> all outputs 0 immediately; no done; a new start behaves normally.

Source files
------------

// File: rtl/tbec_rsc_pkg.sv
// Shared TBEC-RSC types and the 16->32 encode function used by RTL and scoreboard.
// Latency: n/a (package). Backpressure: n/a.
// Codeword bit 0 is the MSB; the data half is the 4x4 transpose of the user word.
package tbec_rsc_pkg;

    localparam int DATA_W = 16;
    localparam int CW_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [0:DATA_W-1] dataword_t;
    typedef logic [0:CW_W-1]   codeword_t;

    function automatic codeword_t tbec_rsc_encode(input dataword_t d);
        codeword_t           cw;
        logic [0:DATA_W-1]   red;
        cw  = '0;
        red = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                cw[r + 4*k] = d[4*r + k];
            end
            red[8 + 2*r] = d[4*r]     ^ d[4*r + 2];
            red[9 + 2*r] = d[4*r + 1] ^ d[4*r + 3];
        end
        // Pair bits cover rows {0,1} and {2,3}; the odd slots are swapped between halves.
        for (int h = 0; h < 2; h++) begin
            red[4 + 2*h] = d[8*h]     ^ d[8*h + 1] ^ d[8*h + 4] ^ d[8*h + 5];
            red[7 - 2*h] = d[8*h + 2] ^ d[8*h + 3] ^ d[8*h + 6] ^ d[8*h + 7];
        end
        red[0] = d[0] ^ d[5] ^ d[8]  ^ d[13];
        red[2] = d[1] ^ d[4] ^ d[9]  ^ d[12];
        red[3] = d[2] ^ d[7] ^ d[10] ^ d[15];
        red[1] = d[3] ^ d[6] ^ d[11] ^ d[14];
        for (int i = 0; i < DATA_W; i++) begin
            cw[DATA_W + i] = red[i];
        end
        return cw;
    endfunction

endpackage

// File: rtl/tbec_rsc_encoder.sv
// TBEC-RSC encoder: user word to 32-bit codeword.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module tbec_rsc_encoder
    import tbec_rsc_pkg::*;
(
    input  logic [0:DATA_W-1] data,
    output logic [0:CW_W-1]   cw
);

    always_comb begin
        cw = tbec_rsc_encode(data);
    end

endmodule

// File: rtl/tbec_rsc_write_port.sv
// TBEC-RSC write port: encodes stream words and bursts them to memory; TBEC_ERR_INJECT_EN adds inj_mask/inj_en.
// Latency: 1 cycle from input accept to mem_wr_valid.
// Backpressure: single holding register; in_ready drops while it is full and memory stalls.
module tbec_rsc_write_port
    import tbec_rsc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [0:DATA_W-1] in_data,
    output logic              in_ready,
`ifdef TBEC_ERR_INJECT_EN
    input  logic [0:CW_W-1]   inj_mask,
    input  logic              inj_en,
`endif
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [0:CW_W-1]   mem_wr_data,
    input  logic              mem_wr_ready
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    remaining;
    logic                hold_full;
    logic [ADDR_W-1:0]   hold_addr;
    logic [0:CW_W-1]     hold_data;
    logic [0:CW_W-1]     enc_cw;
    logic [0:CW_W-1]     store_cw;
    logic                accept;
    logic                wr_hs;

    tbec_rsc_encoder u_encoder (
        .data (in_data),
        .cw   (enc_cw)
    );

`ifdef TBEC_ERR_INJECT_EN
    assign store_cw = inj_en ? (enc_cw ^ inj_mask) : enc_cw;
`else
    assign store_cw = enc_cw;
`endif

    assign accept = in_valid & in_ready;
    assign wr_hs  = hold_full & mem_wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (burst_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept && remaining == LEN_W'(1)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_hs) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_RUN) || (state == ST_DRAIN);
        done     = (state == ST_DONE);
        in_ready = (state == ST_RUN) && (!hold_full || mem_wr_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (state == ST_IDLE && start) begin
            addr      <= base_addr;
            remaining <= burst_len;
        end else if (accept) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // A same-cycle drain and accept simply reloads, keeping full rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_addr <= addr;
            hold_data <= store_cw;
        end else if (wr_hs) begin
            hold_full <= 1'b0;
        end
    end

    assign mem_wr_valid = hold_full;
    assign mem_wr_addr  = hold_addr;
    assign mem_wr_data  = hold_data;

endmodule

// File: tb/tb_tbec_rsc_write_port.sv
// Directed bench for tbec_rsc_write_port: vector table of single-word bursts plus multi-cycle sequences.
module tb_tbec_rsc_write_port;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  burst_len;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic [0:15] in_data;
    logic        in_ready;
    logic        mem_wr_valid;
    logic [9:0]  mem_wr_addr;
    logic [0:31] mem_wr_data;
    logic        mem_wr_ready;
`ifdef TBEC_ERR_INJECT_EN
    logic [0:31] inj_mask;
    logic        inj_en;
`endif

    tbec_rsc_write_port #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .burst_len    (burst_len),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
`ifdef TBEC_ERR_INJECT_EN
        .inj_mask     (inj_mask),
        .inj_en       (inj_en),
`endif
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] words [256];
    logic [9:0]  wq_addr [$];
    logic [31:0] wq_data [$];
    int r_hs, r_done_n, r_done_cyc, r_last_hs, stab_err, ir_err;

    typedef struct {
        logic [15:0] din;
        logic [9:0]  base;
        logic [31:0] exp_cw;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [0:31] enc_model(input logic [0:15] d);
        logic [0:31] c;
        logic [0:15] rd;
        c[0:15] = {d[0], d[4], d[8],  d[12], d[1], d[5], d[9],  d[13],
                   d[2], d[6], d[10], d[14], d[3], d[7], d[11], d[15]};
        rd[0]  = d[0] ^ d[5] ^ d[8]  ^ d[13];
        rd[1]  = d[3] ^ d[6] ^ d[11] ^ d[14];
        rd[2]  = d[1] ^ d[4] ^ d[9]  ^ d[12];
        rd[3]  = d[2] ^ d[7] ^ d[10] ^ d[15];
        rd[4]  = d[0] ^ d[1] ^ d[4]  ^ d[5];
        rd[5]  = d[10] ^ d[11] ^ d[14] ^ d[15];
        rd[6]  = d[8] ^ d[9] ^ d[12] ^ d[13];
        rd[7]  = d[2] ^ d[3] ^ d[6]  ^ d[7];
        rd[8]  = d[0]  ^ d[2];
        rd[9]  = d[1]  ^ d[3];
        rd[10] = d[4]  ^ d[6];
        rd[11] = d[5]  ^ d[7];
        rd[12] = d[8]  ^ d[10];
        rd[13] = d[9]  ^ d[11];
        rd[14] = d[12] ^ d[14];
        rd[15] = d[13] ^ d[15];
        c[16:31] = rd;
        return c;
    endfunction

    function automatic logic [0:15] dec_data(input logic [0:31] c);
        logic [0:15] d;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                d[4*r + k] = c[r + 4*k];
        return d;
    endfunction

    function automatic logic [15:0] syndrome(input logic [0:31] c);
        logic [0:31] re;
        re = enc_model(dec_data(c));
        return re[16:31] ^ c[16:31];
    endfunction

    // mode 0: mem_wr_ready held high; mode 1: toggles 1,0,1,0...
    task automatic run_burst(input logic [9:0] base, input logic [9:0] len,
                             input int mode, input int abort_after);
        int idx, cyc, post;
        bit seen, acc, prev_stall;
        logic [9:0]  p_addr;
        logic [31:0] p_data;
        wq_addr.delete();
        wq_data.delete();
        r_hs = 0; r_done_n = 0; r_done_cyc = -1; r_last_hs = -1;
        stab_err = 0; ir_err = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; burst_len = len;
        in_valid = 1'b0; mem_wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; idx = 0;
        in_valid = (len != 0); in_data = words[0];
        cyc = 1; seen = 0; post = 0; prev_stall = 0; p_addr = '0; p_data = '0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (prev_stall && (!mem_wr_valid || mem_wr_addr != p_addr || mem_wr_data != p_data))
                stab_err++;
            if (mem_wr_valid && !mem_wr_ready && in_ready) ir_err++;
            prev_stall = mem_wr_valid && !mem_wr_ready;
            p_addr = mem_wr_addr; p_data = mem_wr_data;
            acc = in_valid && in_ready;
            if (mem_wr_valid && mem_wr_ready) begin
                wq_addr.push_back(mem_wr_addr);
                wq_data.push_back(mem_wr_data);
                r_last_hs = cyc;
                r_hs++;
            end
            if (done) begin
                r_done_n++;
                if (!seen) r_done_cyc = cyc;
                seen = 1;
            end
            if (abort_after != 0 && r_hs == abort_after) break;
            if (seen) post++;
            if (post > 3) break;
            @(posedge clk); #1;
            if (acc) idx++;
            in_valid = (idx < int'(len));
            in_data = (idx < 256) ? words[idx] : 16'h0;
            mem_wr_ready = (mode == 0) ? 1'b1 : cyc[0];
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    vec_t vecs [7];
    logic [0:31] flip;

    initial begin
        rst = 1'b1; start = 0; base_addr = 0; burst_len = 0;
        in_valid = 0; in_data = 0; mem_wr_ready = 0;
`ifdef TBEC_ERR_INJECT_EN
        inj_mask = '0; inj_en = 1'b0;
`endif
        vecs[0] = '{16'h8000, 10'h010, 32'h8000_8880};
        vecs[1] = '{16'h0000, 10'h011, 32'h0000_0000};
        vecs[2] = '{16'hFFFF, 10'h012, 32'hFFFF_0000};
        vecs[3] = '{16'h0001, 10'h013, 32'h0001_1401};
        vecs[4] = '{16'h4000, 10'h014, 32'h0800_2840};
        vecs[5] = '{16'h5000, 10'h015, 32'h0808_6900};
        vecs[6] = '{16'hF000, 10'h016, 32'h8888_F000};

        #12;
        check("reset_outputs", {busy, done, in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data},
              64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            words[0] = vecs[i].din;
            run_burst(vecs[i].base, 10'd1, 0, 0);
            check($sformatf("v%0d_nwrites", i), wq_data.size(), 1);
            if (wq_data.size() == 1) begin
                check($sformatf("v%0d_addr", i), wq_addr[0], vecs[i].base);
                check($sformatf("v%0d_data", i), wq_data[0], vecs[i].exp_cw);
            end
            check($sformatf("v%0d_done_n", i), r_done_n, 1);
            check($sformatf("v%0d_done_lat", i), r_done_cyc, r_last_hs + 1);
            check($sformatf("v%0d_busy_after", i), busy, 0);
        end

        // Back-to-back random burst, each codeword checked and round-tripped.
        for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
        run_burst(10'h100, 10'd256, 0, 0);
        check("rand_nwrites", wq_data.size(), 256);
        check("rand_full_rate", r_last_hs, 257);
        for (int i = 0; i < 256 && i < wq_data.size(); i++) begin
            check("rand_addr", wq_addr[i], 10'h100 + 10'(i));
            check("rand_data", wq_data[i], enc_model(words[i]));
            check("rand_decode", dec_data(wq_data[i]), words[i]);
            check("rand_syn0", syndrome(wq_data[i]), 16'h0);
            flip = wq_data[i] ^ (32'h8000_0000 >> $urandom_range(31, 0));
            check("rand_syn1_nz", syndrome(flip) != 16'h0, 1'b1);
        end

        // Backpressure with alternating mem_wr_ready.
        for (int i = 0; i < 4; i++) words[i] = 16'h1234 + 16'(i * 16'h1111);
        run_burst(10'h020, 10'd4, 1, 0);
        check("bp_nwrites", wq_data.size(), 4);
        for (int i = 0; i < 4 && i < wq_data.size(); i++) begin
            check("bp_addr", wq_addr[i], 10'h020 + 10'(i));
            check("bp_data", wq_data[i], enc_model(words[i]));
        end
        check("bp_stable", stab_err, 0);
        check("bp_in_ready_low", ir_err, 0);
        check("bp_done_n", r_done_n, 1);

        // Address wrap.
        for (int i = 0; i < 3; i++) words[i] = 16'hA5A5 ^ 16'(i);
        run_burst(10'h3FE, 10'd3, 0, 0);
        check("wrap_nwrites", wq_addr.size(), 3);
        if (wq_addr.size() == 3) begin
            check("wrap_a0", wq_addr[0], 10'h3FE);
            check("wrap_a1", wq_addr[1], 10'h3FF);
            check("wrap_a2", wq_addr[2], 10'h000);
        end

        // Zero length.
        run_burst(10'h055, 10'd0, 0, 0);
        check("zero_nwrites", wq_addr.size(), 0);
        check("zero_done_lat", r_done_cyc, 1);
        check("zero_done_n", r_done_n, 1);

        // Reset mid-burst after two writes.
        for (int i = 0; i < 5; i++) words[i] = 16'h0F0F + 16'(i);
        run_burst(10'h0C0, 10'd5, 0, 2);
        check("abort_hs", r_hs, 2);
        rst = 1'b1;
        #1;
        check("abort_outputs", {busy, done, in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data},
              64'h0);
        r_done_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || mem_wr_valid) r_done_n++;
        end
        check("abort_quiet", r_done_n, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        words[0] = 16'h8000; words[1] = 16'h0001;
        run_burst(10'h200, 10'd2, 0, 0);
        check("restart_nwrites", wq_data.size(), 2);
        if (wq_data.size() == 2) begin
            check("restart_a0", wq_addr[0], 10'h200);
            check("restart_d0", wq_data[0], 32'h8000_8880);
            check("restart_a1", wq_addr[1], 10'h201);
            check("restart_d1", wq_data[1], 32'h0001_1401);
        end
        check("restart_done_n", r_done_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
